// File: rtl/seven_segment_anim_ctrl.sv
// Button front-end and frame timer for the 7-segment animation tile.
// Debounced buttons select animation and speed; a prescaler paces frame_idx.
module seven_segment_anim_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int NUM_ANIM        = 6,
  parameter int FRAMES_PER_ANIM = 8,
  parameter int SPEED_LEVELS    = 8,
  parameter int BASE_DIV        = 125000
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               ena,
  input  logic [3:0]                         btn_raw,
  output logic [$clog2(NUM_ANIM)-1:0]        anim_sel,
  output logic [$clog2(FRAMES_PER_ANIM)-1:0] frame_idx,
  output logic [$clog2(SPEED_LEVELS)-1:0]    speed_lvl,
  output logic                               frame_tick,
  output logic [3:0]                         btn_evt
);
  localparam int AW   = $clog2(NUM_ANIM);
  localparam int FW   = $clog2(FRAMES_PER_ANIM);
  localparam int SW   = $clog2(SPEED_LEVELS);
  localparam int DW   = $clog2(DEBOUNCE_CYCLES);
  localparam int PMAX = BASE_DIV * SPEED_LEVELS;
  localparam int PW   = $clog2(PMAX);
  localparam int PCW  = PW + 1;

  localparam logic [AW-1:0] ANIM_MAX   = AW'(NUM_ANIM - 1);
  localparam logic [FW-1:0] FRAME_MAX  = FW'(FRAMES_PER_ANIM - 1);
  localparam logic [SW-1:0] SPEED_MAX  = SW'(SPEED_LEVELS - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    sync1, sync2, stable, stable_d;
  logic [DW-1:0] db_cnt [4];
  logic [PW-1:0] prescale;
  logic [PCW-1:0] period;
  logic          period_end;
  logic          inc_anim, dec_anim, inc_spd, dec_spd, anim_chg, spd_chg;
  logic [AW-1:0] anim_next;
  logic [SW-1:0] speed_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // A bit only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_d <= '0;
      btn_evt  <= '0;
    end else begin
      stable_d <= stable;
      btn_evt  <= stable & ~stable_d;
    end
  end

  // Opposing presses in the same cycle cancel; saturated speed presses are no-ops.
  always_comb begin
    inc_anim = ena & btn_evt[0] & ~btn_evt[1];
    dec_anim = ena & btn_evt[1] & ~btn_evt[0];
    inc_spd  = ena & btn_evt[2] & ~btn_evt[3] & (speed_lvl != SPEED_MAX);
    dec_spd  = ena & btn_evt[3] & ~btn_evt[2] & (speed_lvl != '0);
    anim_chg = inc_anim | dec_anim;
    spd_chg  = inc_spd | dec_spd;

    anim_next = anim_sel;
    if (inc_anim)
      anim_next = (anim_sel == ANIM_MAX) ? '0 : anim_sel + 1'b1;
    else if (dec_anim)
      anim_next = (anim_sel == '0) ? ANIM_MAX : anim_sel - 1'b1;

    speed_next = speed_lvl;
    if (inc_spd)
      speed_next = speed_lvl + 1'b1;
    else if (dec_spd)
      speed_next = speed_lvl - 1'b1;

    period     = PCW'(BASE_DIV) * (PCW'(SPEED_LEVELS) - PCW'(speed_lvl));
    period_end = ({1'b0, prescale} == period - 1'b1);
  end

  // A selection change restarts the frame period and beats a coincident tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anim_sel   <= '0;
      speed_lvl  <= '0;
      frame_idx  <= '0;
      frame_tick <= 1'b0;
      prescale   <= '0;
    end else begin
      frame_tick <= 1'b0;
      anim_sel   <= anim_next;
      speed_lvl  <= speed_next;
      if (anim_chg || spd_chg) begin
        prescale <= '0;
        if (anim_chg) frame_idx <= '0;
      end else if (ena) begin
        if (period_end) begin
          prescale   <= '0;
          frame_idx  <= (frame_idx == FRAME_MAX) ? '0 : frame_idx + 1'b1;
          frame_tick <= 1'b1;
        end else begin
          prescale <= prescale + 1'b1;
        end
      end
    end
  end

endmodule
